cp0_regfile: RTL and testbench
==============================

# cp0_regfile

Coprocessor-0 register file and exception state keeper for the SimpleCPU pipeline. It sits directly upstream of `exception_handler`: it supplies the live `cp0_status`, `cp0_cause` and `cp0_epc` words and receives back the resolved exception id. On that id it commits the architectural side effects (EPC capture, EXL set/clear, ExcCode, BadVAddr) and produces the redirect target and pipeline flush. It also owns the Count/Compare timer and the hardware interrupt pending bits.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register width. Only 32 is supported.
- `EXCEPT_VECTOR`, 32'h0000_0020: handler entry address for every exception except ERET.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `hw_int`  in  6  level-sensitive external interrupt lines.
- `wb_wb_cp0`  in  1  MTC0 write enable from the WB stage.
- `wb_cp0_write_addr`  in  `CP0_REG_BUS`  MTC0 destination register number.
- `wb_cp0_write`  in  32  MTC0 write data.
- `rd_addr`  in  `CP0_REG_BUS`  MFC0 read address.
- `rd_data`  out  32  MFC0 read data (combinational).
- `exception`  in  32  exception id from `exception_handler`; `EXCEPT_NONE` means idle.
- `pc`  in  32  PC of the faulting instruction.
- `in_delay_slot`  in  1  faulting instruction is in a branch delay slot.
- `bad_addr`  in  32  faulting data address, for ADDRL/ADDRS.
- `cp0_status`, `cp0_cause`, `cp0_epc`  out  32 each  current register values, with WB bypass.
- `flush`  out  1  combinational; high whenever `exception != EXCEPT_NONE`.
- `exception_target`  out  32  combinational; EPC for ERET, `EXCEPT_VECTOR` otherwise, 0 when idle.

## Operation
Registers (number: name):
- 8: BadVAddr.
- 9: Count.
- 11: Compare.
- 12: Status.
  - Writable bits: [15:8] IM, [1] EXL, [0] IE. All other bits read 0.
- 13: Cause.
  - [31] BD.
  - [15:10] IP hardware bits, read-only.
  - [9:8] IP software bits, writable.
  - [6:2] ExcCode.
  - All other bits read 0.
- 14: EPC.
- Any other address reads 0; writes to it are ignored.

Per cycle (each step applies to the next rising edge unless stated):
- Count increments by 1 and wraps from 0xFFFF_FFFF to 0. An MTC0 to Count overrides the increment.
- Timer pending (TI) latches to 1 when Count == Compare and Compare != 0.
  - TI clears only on an MTC0 to Compare.
  - If that Compare write coincides with a match, the write wins and TI = 0.
- Cause[15:10] is registered each cycle as {`hw_int[5]` | TI, `hw_int[4:0]`}.

Exception commit (`exception` != NONE and != ERET):
- EPC = `in_delay_slot` ? `pc` - 4 : `pc`.
- Cause.BD = `in_delay_slot`.
- Status.EXL = 1.
- Cause.ExcCode is set by exception type:
  - INTERRUPT: 0.
  - ADDRL: 4.
  - ADDRS: 5.
  - SYSCALL: 8.
  - ILLEGAL: 10.
  - OVERFLOW: 12.
  - TRAP: 13.
- For ADDRL/ADDRS only, BadVAddr = `bad_addr`.

ERET:
- Status.EXL = 0.
- No other field changes.

Simultaneous MTC0 and exception/ERET:
- The fields the exception writes (EPC, BD, EXL, ExcCode, BadVAddr) take the exception value.
- All remaining fields take the MTC0 value.

Bypass:
- While `wb_wb_cp0` = 1, the `cp0_status`/`cp0_cause`/`cp0_epc` outputs and `rd_data` return the merged write value for the addressed register in the same cycle.
- The merged value honours writable masks, so read-only bits keep their stored value.

## Timing
- Reset state:
  - All registers are 0.
  - Outputs: `rd_data` = 0, all `cp0_*` = 0, `flush` = 0, `exception_target` = 0.
  - TI = 0.
  - Count is held at 0 during reset and reads 1 on the first cycle after release.
- Reset asserted mid-exception overrides any commit on that edge.
- `flush` and `exception_target` have zero latency. Register side effects are visible one cycle later.
- `hw_int` reaches Cause.IP with 1 cycle of latency. `exception_handler` sees the interrupt on that same cycle.
- No exception is nested while EXL = 1. `exception_handler` gates interrupts on this; synchronous exceptions still commit and overwrite EPC.

## Test plan
- Reset release: Status, Cause, EPC and Count read 0 → one cycle later, Count reads 1.
- MTC0 Status = 0x0000_FF01 → same cycle `cp0_status` = 0x0000_FF01 (bypass); it persists after `wb_wb_cp0` drops. MFC0 12 returns the same value.
- Syscall, pc = 0x100, `in_delay_slot` = 1 → `flush` = 1 and target 0x20 that cycle; next cycle EPC = 0xFC, Cause = 0x8000_0020, Status.EXL = 1.
- Then ERET → target 0xFC that cycle; next cycle EXL = 0 and EPC is unchanged.
- Write Compare = 5 right after reset → TI sets and Cause[15] = 1 after Count reaches 5. A subsequent Compare write clears Cause[15] on the following cycle.
- ADDRS, `bad_addr` = 0x1003, together with MTC0 EPC = 0x40 → EPC = `pc`, BadVAddr = 0x1003, ExcCode = 5.

Source files
------------

// File: rtl/cp0_regfile.sv
// cp0_regfile
// Coprocessor-0 register file and exception state keeper. Holds BadVAddr,
// Count, Compare, Status, Cause and EPC, owns the Count/Compare timer and
// the hardware interrupt pending bits, and commits the architectural side
// effects of the exception id returned by exception_handler.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   hw_int[5:0]         level-sensitive external interrupt lines
//   wb_wb_cp0           MTC0 write enable (WB stage)
//   wb_cp0_write_addr   MTC0 destination register number
//   wb_cp0_write        MTC0 write data
//   rd_addr, rd_data    MFC0 read port (combinational, with WB bypass)
//   exception           resolved exception id (EXC_NONE = idle)
//   pc, in_delay_slot   faulting instruction PC and delay-slot flag
//   bad_addr            faulting data address for ADDRL/ADDRS
//   cp0_status/cause/epc  live register values with WB bypass
//   flush               high whenever an exception id is presented
//   exception_target    redirect PC: EPC for ERET, vector otherwise, 0 idle
module cp0_regfile #(
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] EXCEPT_VECTOR = 32'h0000_0020
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            hw_int,
    input  logic                  wb_wb_cp0,
    input  logic [4:0]            wb_cp0_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_cp0_write,
    input  logic [4:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [31:0]           exception,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  in_delay_slot,
    input  logic [DATA_WIDTH-1:0] bad_addr,
    output logic [DATA_WIDTH-1:0] cp0_status,
    output logic [DATA_WIDTH-1:0] cp0_cause,
    output logic [DATA_WIDTH-1:0] cp0_epc,
    output logic                  flush,
    output logic [DATA_WIDTH-1:0] exception_target
);

    // Exception ids shared with exception_handler.
    localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_ADDRL     = 32'h0000_0004;
    localparam logic [31:0] EXC_ADDRS     = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_ILLEGAL   = 32'h0000_000A;
    localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000C;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000D;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000E;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Bits an MTC0 may change; everything else keeps its stored value.
    localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_MASK  = 32'h0000_0300;

    function automatic logic [31:0] merge_masked(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (new_val & mask) | (old_val & ~mask);
    endfunction

    logic [31:0] badvaddr_r, count_r, compare_r, status_r, cause_r, epc_r;
    logic        ti_r;

    logic        wr_badvaddr_s, wr_count_s, wr_compare_s;
    logic        wr_status_s, wr_cause_s, wr_epc_s;
    logic        is_eret_s, is_exc_s;
    logic [31:0] badvaddr_byp_s, count_byp_s, compare_byp_s;
    logic [31:0] status_byp_s, cause_byp_s, epc_byp_s;
    logic [31:0] badvaddr_next_s, count_next_s, compare_next_s;
    logic [31:0] status_next_s, cause_next_s, epc_next_s;
    logic        ti_next_s;
    logic [4:0]  exc_code_s;

    assign wr_badvaddr_s = wb_wb_cp0 && (wb_cp0_write_addr == REG_BADVADDR);
    assign wr_count_s    = wb_wb_cp0 && (wb_cp0_write_addr == REG_COUNT);
    assign wr_compare_s  = wb_wb_cp0 && (wb_cp0_write_addr == REG_COMPARE);
    assign wr_status_s   = wb_wb_cp0 && (wb_cp0_write_addr == REG_STATUS);
    assign wr_cause_s    = wb_wb_cp0 && (wb_cp0_write_addr == REG_CAUSE);
    assign wr_epc_s      = wb_wb_cp0 && (wb_cp0_write_addr == REG_EPC);

    assign is_eret_s = (exception == EXC_ERET);
    assign is_exc_s  = (exception != EXC_NONE) && !is_eret_s;

    // Same-cycle view of each register including a pending MTC0.
    assign badvaddr_byp_s = wr_badvaddr_s ? wb_cp0_write : badvaddr_r;
    assign count_byp_s    = wr_count_s    ? wb_cp0_write : count_r;
    assign compare_byp_s  = wr_compare_s  ? wb_cp0_write : compare_r;
    assign status_byp_s   = wr_status_s ? merge_masked(status_r, wb_cp0_write, STATUS_MASK) : status_r;
    assign cause_byp_s    = wr_cause_s  ? merge_masked(cause_r, wb_cp0_write, CAUSE_MASK) : cause_r;
    assign epc_byp_s      = wr_epc_s      ? wb_cp0_write : epc_r;

    assign cp0_status = status_byp_s;
    assign cp0_cause  = cause_byp_s;
    assign cp0_epc    = epc_byp_s;
    assign flush      = (exception != EXC_NONE);

    // Redirect target for the current exception id.
    always_comb begin
        exception_target = 32'h0000_0000;
        if (is_eret_s) begin
            exception_target = epc_byp_s;
        end else if (is_exc_s) begin
            exception_target = EXCEPT_VECTOR;
        end else begin
            exception_target = 32'h0000_0000;
        end
    end

    // MFC0 read mux.
    always_comb begin
        rd_data = 32'h0000_0000;
        case (rd_addr)
            REG_BADVADDR: rd_data = badvaddr_byp_s;
            REG_COUNT:    rd_data = count_byp_s;
            REG_COMPARE:  rd_data = compare_byp_s;
            REG_STATUS:   rd_data = status_byp_s;
            REG_CAUSE:    rd_data = cause_byp_s;
            REG_EPC:      rd_data = epc_byp_s;
            default:      rd_data = 32'h0000_0000;
        endcase
    end

    // ExcCode for the committing exception; unknown ids keep the old code.
    always_comb begin
        exc_code_s = cause_r[6:2];
        case (exception)
            EXC_INTERRUPT: exc_code_s = 5'd0;
            EXC_ADDRL:     exc_code_s = 5'd4;
            EXC_ADDRS:     exc_code_s = 5'd5;
            EXC_SYSCALL:   exc_code_s = 5'd8;
            EXC_ILLEGAL:   exc_code_s = 5'd10;
            EXC_OVERFLOW:  exc_code_s = 5'd12;
            EXC_TRAP:      exc_code_s = 5'd13;
            default:       exc_code_s = cause_r[6:2];
        endcase
    end

    // Next-state values: MTC0 first, then the exception fields on top.
    always_comb begin
        count_next_s   = wr_count_s ? wb_cp0_write : (count_r + 32'd1);
        compare_next_s = compare_byp_s;

        // A Compare write beats a coincident match.
        ti_next_s = ti_r;
        if (wr_compare_s) begin
            ti_next_s = 1'b0;
        end else if ((count_r == compare_r) && (compare_r != 32'h0000_0000)) begin
            ti_next_s = 1'b1;
        end else begin
            ti_next_s = ti_r;
        end

        status_next_s = status_byp_s;
        if (is_exc_s) begin
            status_next_s[1] = 1'b1;
        end else if (is_eret_s) begin
            status_next_s[1] = 1'b0;
        end else begin
            status_next_s[1] = status_byp_s[1];
        end

        // TI is folded in from its next value so Cause[15] tracks TI exactly.
        cause_next_s        = cause_byp_s;
        cause_next_s[15:10] = {hw_int[5] | ti_next_s, hw_int[4:0]};
        if (is_exc_s) begin
            cause_next_s[31]  = in_delay_slot;
            cause_next_s[6:2] = exc_code_s;
        end else begin
            cause_next_s[31]  = cause_byp_s[31];
            cause_next_s[6:2] = cause_byp_s[6:2];
        end

        if (is_exc_s) begin
            epc_next_s = in_delay_slot ? (pc - 32'd4) : pc;
        end else begin
            epc_next_s = epc_byp_s;
        end

        if (is_exc_s && ((exception == EXC_ADDRL) || (exception == EXC_ADDRS))) begin
            badvaddr_next_s = bad_addr;
        end else begin
            badvaddr_next_s = badvaddr_byp_s;
        end
    end

    // Register update; reset wins over any commit on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_r <= 32'h0000_0000;
            count_r    <= 32'h0000_0000;
            compare_r  <= 32'h0000_0000;
            status_r   <= 32'h0000_0000;
            cause_r    <= 32'h0000_0000;
            epc_r      <= 32'h0000_0000;
            ti_r       <= 1'b0;
        end else begin
            badvaddr_r <= badvaddr_next_s;
            count_r    <= count_next_s;
            compare_r  <= compare_next_s;
            status_r   <= status_next_s;
            cause_r    <= cause_next_s;
            epc_r      <= epc_next_s;
            ti_r       <= ti_next_s;
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile
// Directed bench for cp0_regfile: reset state, Count, MTC0 bypass and masks,
// Count/Compare timer, exception commit, ERET, MTC0/exception collision,
// hw_int latency, Count wrap, reset during exception, unmapped addresses.
module tb_cp0_regfile;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_ADDRS   = 32'h0000_0005;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_ILLEGAL = 32'h0000_000A;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

    logic        clk;
    logic        rst;
    logic [5:0]  hw_int;
    logic        wb_wb_cp0;
    logic [4:0]  wb_cp0_write_addr;
    logic [31:0] wb_cp0_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] exception;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic [31:0] bad_addr;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        flush;
    logic [31:0] exception_target;

    int n_cmp = 0;
    int n_err = 0;

    cp0_regfile #(.DATA_WIDTH(32), .EXCEPT_VECTOR(32'h0000_0020)) dut (
        .clk(clk), .rst(rst), .hw_int(hw_int),
        .wb_wb_cp0(wb_wb_cp0), .wb_cp0_write_addr(wb_cp0_write_addr),
        .wb_cp0_write(wb_cp0_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .exception(exception), .pc(pc), .in_delay_slot(in_delay_slot),
        .bad_addr(bad_addr), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .flush(flush), .exception_target(exception_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_wb_cp0 = en;
        wb_cp0_write_addr = a;
        wb_cp0_write = d;
    endtask

    initial begin
        rst = 1'b1; hw_int = 6'd0; mtc0(1'b0, 5'd0, 32'h0000_0000);
        rd_addr = 5'd9; exception = EXC_NONE; pc = 32'h0000_0000;
        in_delay_slot = 1'b0; bad_addr = 32'h0000_0000;
        tick();
        tick();

        // Reset state.
        chk("rst_status", cp0_status, 32'h0000_0000);
        chk("rst_cause", cp0_cause, 32'h0000_0000);
        chk("rst_epc", cp0_epc, 32'h0000_0000);
        chk("rst_count", rd_data, 32'h0000_0000);
        chk("rst_flush", {31'd0, flush}, 32'h0000_0000);
        chk("rst_target", exception_target, 32'h0000_0000);

        // Release; Compare = 5 in the first cycle.
        rst = 1'b0;
        mtc0(1'b1, 5'd11, 32'h0000_0005);
        #1;
        chk("count_first", rd_data, 32'h0000_0000);
        tick();
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        #1;
        chk("count_one", rd_data, 32'h0000_0001);

        // Status write: bypass and read-only masking.
        mtc0(1'b1, 5'd12, 32'hFFFF_FF01);
        rd_addr = 5'd12;
        #1;
        chk("status_bypass", cp0_status, 32'h0000_FF01);
        chk("status_mfc0_bypass", rd_data, 32'h0000_FF01);
        tick();
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        #1;
        chk("status_persist", cp0_status, 32'h0000_FF01);
        chk("status_mfc0", rd_data, 32'h0000_FF01);
        tick();

        // Cause write only reaches IP software bits.
        mtc0(1'b1, 5'd13, 32'hFFFF_FFFF);
        #1;
        chk("cause_mask", cp0_cause, 32'h0000_0300);
        tick();
        mtc0(1'b1, 5'd13, 32'h0000_0000);
        #1;
        chk("cause_clear_bypass", cp0_cause, 32'h0000_0000);
        tick();

        // Timer: Count now 5, TI sets on the next edge.
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        rd_addr = 5'd9;
        #1;
        chk("count_five", rd_data, 32'h0000_0005);
        chk("ti_not_yet", cp0_cause, 32'h0000_0000);
        tick();
        chk("count_six", rd_data, 32'h0000_0006);
        chk("ti_set", cp0_cause, 32'h0000_8000);
        mtc0(1'b1, 5'd11, 32'h0000_0064);
        tick();
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        rd_addr = 5'd11;
        #1;
        chk("ti_cleared", cp0_cause, 32'h0000_0000);
        chk("compare_rd", rd_data, 32'h0000_0064);

        // Syscall in delay slot.
        exception = EXC_SYSCALL; pc = 32'h0000_0100; in_delay_slot = 1'b1;
        #1;
        chk("sys_flush", {31'd0, flush}, 32'h0000_0001);
        chk("sys_target", exception_target, 32'h0000_0020);
        tick();
        exception = EXC_NONE; in_delay_slot = 1'b0;
        #1;
        chk("sys_epc", cp0_epc, 32'h0000_00FC);
        chk("sys_cause", cp0_cause, 32'h8000_0020);
        chk("sys_status", cp0_status, 32'h0000_FF03);
        chk("idle_flush", {31'd0, flush}, 32'h0000_0000);
        chk("idle_target", exception_target, 32'h0000_0000);

        // ERET.
        exception = EXC_ERET;
        #1;
        chk("eret_target", exception_target, 32'h0000_00FC);
        chk("eret_flush", {31'd0, flush}, 32'h0000_0001);
        tick();
        exception = EXC_NONE;
        #1;
        chk("eret_status", cp0_status, 32'h0000_FF01);
        chk("eret_epc", cp0_epc, 32'h0000_00FC);
        chk("eret_cause", cp0_cause, 32'h8000_0020);

        // ADDRS together with MTC0 EPC.
        exception = EXC_ADDRS; pc = 32'h0000_0200; bad_addr = 32'h0000_1003;
        mtc0(1'b1, 5'd14, 32'h0000_0040);
        #1;
        chk("addrs_target", exception_target, 32'h0000_0020);
        chk("epc_bypass", cp0_epc, 32'h0000_0040);
        tick();
        exception = EXC_NONE;
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        rd_addr = 5'd8;
        #1;
        chk("addrs_epc", cp0_epc, 32'h0000_0200);
        chk("addrs_badvaddr", rd_data, 32'h0000_1003);
        chk("addrs_cause", cp0_cause, 32'h0000_0014);
        chk("addrs_status", cp0_status, 32'h0000_FF03);

        // ILLEGAL together with MTC0 Status = 0: EXL from exception, rest from MTC0.
        exception = EXC_ILLEGAL; pc = 32'h0000_0300; bad_addr = 32'h0000_BEEF;
        mtc0(1'b1, 5'd12, 32'h0000_0000);
        tick();
        exception = EXC_NONE;
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        #1;
        chk("ill_status", cp0_status, 32'h0000_0002);
        chk("ill_cause", cp0_cause, 32'h0000_0028);
        chk("ill_epc", cp0_epc, 32'h0000_0300);
        chk("ill_badvaddr_kept", rd_data, 32'h0000_1003);

        // hw_int reaches Cause.IP one cycle later.
        hw_int = 6'b100101;
        #1;
        chk("hw_int_latency", cp0_cause, 32'h0000_0028);
        tick();
        chk("hw_int_ip", cp0_cause, 32'h0000_9428);
        hw_int = 6'd0;
        tick();
        chk("hw_int_drop", cp0_cause, 32'h0000_0028);

        // Count wrap.
        mtc0(1'b1, 5'd9, 32'hFFFF_FFFF);
        rd_addr = 5'd9;
        tick();
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        #1;
        chk("count_max", rd_data, 32'hFFFF_FFFF);
        tick();
        chk("count_wrap", rd_data, 32'h0000_0000);

        // Reset during an exception.
        exception = EXC_SYSCALL; pc = 32'h0000_0500; rst = 1'b1;
        tick();
        exception = EXC_NONE;
        #1;
        chk("rst_exc_epc", cp0_epc, 32'h0000_0000);
        chk("rst_exc_status", cp0_status, 32'h0000_0000);
        chk("rst_exc_cause", cp0_cause, 32'h0000_0000);
        rst = 1'b0;

        // Unmapped register.
        mtc0(1'b1, 5'd5, 32'hFFFF_FFFF);
        rd_addr = 5'd5;
        #1;
        chk("unmapped_bypass", rd_data, 32'h0000_0000);
        tick();
        mtc0(1'b0, 5'd0, 32'h0000_0000);
        #1;
        chk("unmapped_rd", rd_data, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
